mdu_sched: RTL and testbench
============================

// Module: mdu_sched
// PURPOSE
//  Multiply/divide scheduler for the 5-stage pipeline. Accepts MDU ops from EX, holds HI/LO,
//  and sequences multi-cycle mult/div with a latency counter. Drives busy to the pipeline
//  and raises a stall for any ID-stage MDU instruction while an op is in flight.
//  Sits beside the ALU in EX; its rd_data feeds the EX->MEM result mux for mfhi/mflo.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, synchronous, active-high
//  ex_start   in   1   EX-stage instruction is an MDU op
//  ex_op      in   4   MDU op code (mdu_pkg encoding)
//  ex_a       in   32  forwarded rs value
//  ex_b       in   32  forwarded rt value
//  ex_flush   in   1   exception/flush: suppresses same-cycle ex_start
//  id_mdu_use in   1   ID-stage instruction is an MDU op
//  busy       out  1   mult/div in flight
//  stall_req  out  1   freeze IF/ID, bubble ID/EX
//  hi         out  32  HI register
//  lo         out  32  LO register
//  rd_data    out  32  mfhi -> hi, mflo -> lo, else 0 (combinational on ex_op)
// BEHAVIOUR
//  - Reset: state IDLE, cnt 0, busy 0, hi 0, lo 0, pending regs 0. Reset mid-op aborts the op.
//  - Op codes: NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MFHI 5, MFLO 6, MTHI 7, MTLO 8;
//    9-15 are treated as NONE.
//  - accept = ex_start & ~ex_flush & (state==IDLE).
//  - IDLE + accept + MULT/MULTU/DIV/DIVU (start in cycle T):
//    - compute the result into pend_hi/pend_lo at the T edge;
//    - load cnt = LAT; state becomes BUSY.
//  - BUSY: busy=1 during T+1..T+LAT. cnt decrements each cycle.
//    - At cnt==1: hi/lo <= pend_hi/pend_lo and state returns to IDLE.
//    - New hi/lo is visible at T+LAT+1.
//  - MULT: signed 64-bit product, {hi,lo} = a*b. MULTU: unsigned.
//  - DIV: lo = a/b, hi = a%b, truncated toward zero, remainder takes sign of dividend.
//    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. DIVU: unsigned.
//  - Divide by zero (b==0): op still takes DIV_CYCLES busy, but hi/lo remain unchanged.
//  - MTHI/MTLO accepted in IDLE: hi (or lo) <= ex_a at the next edge, no busy.
//  - MFHI/MFLO: rd_data reflects the current hi/lo. No state change.
//  - stall_req = id_mdu_use & (busy | (accept & op is mult/div)). Combinational.
//  - ex_start while BUSY is a protocol violation. It is ignored, with no state or hi/lo change.
//  - ex_flush does not abort an in-flight op. It only drops the same-cycle start/mt write.
// STRUCTURE
//  - mdu_pkg: op-code localparams, state enum {IDLE, BUSY}, is_muldiv() function.
//  - One sub-module, mdu_arith: combinational 64-bit mult/div result for a given op/a/b.
//  - The FSM, counter, HI/LO and pending regs live in mdu_sched itself.
// TESTING
//  1 MULT a=0xFFFFFFFE(-2) b=3 at T -> busy T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2 DIVU a=17 b=5 -> busy for 10 cycles; then lo=3, hi=2.
//    DIV a=-17 b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE.
//  3 MTHI a=0x12345678, then MFHI next cycle -> rd_data=0x12345678, busy stays 0.
//  4 Stall cases:
//    - id_mdu_use=1 in the same cycle as a MULT start -> stall_req=1 that cycle and throughout busy;
//    - stall_req=0 once busy falls.
//  5 Reset asserted at T+2 of a DIV -> next cycle busy=0, hi=lo=0.
//    ex_start with ex_flush=1 -> no busy, hi/lo unchanged.
//  6 DIV b=0 with hi=0xA, lo=0xB preset -> busy for 10 cycles; hi=0xA, lo=0xB after.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op-code encoding, scheduler state type and op classification
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit mult/div result for one MDU op
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               signed_div;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        div_b;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    assign signed_div = (op == OP_DIV);
    assign a_neg      = signed_div & a[31];
    assign b_neg      = signed_div & b[31];
    assign abs_a      = a_neg ? (~a + 32'd1) : a;
    assign abs_b      = b_neg ? (~b + 32'd1) : b;
    assign div_b      = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign quot_u     = abs_a / div_b;
    assign rem_u      = abs_a % div_b;
    assign quot       = (a_neg ^ b_neg) ? (~quot_u + 32'd1) : quot_u;
    assign rem        = a_neg ? (~rem_u + 32'd1) : rem_u;
    assign div_zero   = is_div(op) & (b == 32'd0);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV,
            OP_DIVU:  begin
                res_hi = rem;
                res_lo = quot;
            end
            default:  ;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - multiply/divide scheduler: HI/LO, latency counter, busy and stall
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_start,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_flush,
    input  logic        id_mdu_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat;
    logic               accept;
    logic               start_md;
    logic               last_cycle;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;
    logic [31:0]        ar_hi;
    logic [31:0]        ar_lo;
    logic               ar_div_zero;

    mdu_arith u_arith (
        .op       (ex_op),
        .a        (ex_a),
        .b        (ex_b),
        .res_hi   (ar_hi),
        .res_lo   (ar_lo),
        .div_zero (ar_div_zero)
    );

    assign lat = is_div(ex_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    always_comb begin
        state_nxt  = state;
        accept     = ex_start & ~ex_flush & (state == ST_IDLE);
        start_md   = accept & is_muldiv(ex_op);
        last_cycle = (state == ST_BUSY) && (cnt == CNT_W'(1));
        busy       = (state == ST_BUSY);
        case (state)
            ST_IDLE: if (start_md) state_nxt = ST_BUSY;
            ST_BUSY: if (last_cycle) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stall_req = id_mdu_use & (busy | start_md);

    always_comb begin
        rd_data = 32'd0;
        if (ex_op == OP_MFHI) rd_data = hi;
        else if (ex_op == OP_MFLO) rd_data = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_md) begin
                pend_hi <= ar_hi;
                pend_lo <= ar_lo;
                pend_wr <= ~ar_div_zero;
                cnt     <= lat;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_W'(1);
                // A divide by zero still spends its cycles but leaves HI/LO alone.
                if (last_cycle && pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
            if (accept && ex_op == OP_MTHI) hi <= ex_a;
            if (accept && ex_op == OP_MTLO) lo <= ex_a;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - directed self-checking bench for mdu_sched
module tb_mdu_sched;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_start;
    logic [3:0]  ex_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        ex_flush;
    logic        id_mdu_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_start   (ex_start),
        .ex_op      (ex_op),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_flush   (ex_flush),
        .id_mdu_use (id_mdu_use),
        .busy       (busy),
        .stall_req  (stall_req),
        .hi         (hi),
        .lo         (lo),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_start   = 1'b0;
        ex_op      = OP_NONE;
        ex_a       = 32'd0;
        ex_b       = 32'd0;
        ex_flush   = 1'b0;
        id_mdu_use = 1'b0;
    endtask

    // Issue a mult/div, count busy cycles, verify HI holds its old value until completion.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        int n;
        old_hi   = hi;
        ex_start = 1'b1;
        ex_op    = op;
        ex_a     = a;
        ex_b     = b;
        tick();
        clear_inputs();
        n = 0;
        while (busy && n < 40) begin
            check_val({tag, "_hold_hi"}, hi, old_hi);
            n++;
            tick();
        end
        check_val({tag, "_lat"}, 32'(n), 32'(lat));
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ex_op = OP_MFHI;
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        check_val("rst_rd", rd_data, 32'd0);
        ex_op = OP_NONE;

        // MULT -2*3 with an ID-stage MDU op waiting alongside
        ex_start   = 1'b1;
        ex_op      = OP_MULT;
        ex_a       = 32'hFFFF_FFFE;
        ex_b       = 32'd3;
        id_mdu_use = 1'b1;
        #1;
        check_val("mult_stall_t", {31'd0, stall_req}, 32'd1);
        tick();
        ex_start = 1'b0;
        ex_op    = OP_NONE;
        for (int i = 1; i <= 5; i++) begin
            check_val("mult_busy", {31'd0, busy}, 32'd1);
            check_val("mult_stall", {31'd0, stall_req}, 32'd1);
            check_val("mult_hi_old", hi, 32'd0);
            tick();
        end
        check_val("mult_busy_end", {31'd0, busy}, 32'd0);
        check_val("mult_stall_end", {31'd0, stall_req}, 32'd0);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFFA);
        clear_inputs();

        run_op("divu", OP_DIVU, 32'd17, 32'd5, 10, 32'd2, 32'd3);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFEF, 32'd5, 10, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("div_negb", OP_DIV, 32'd17, 32'hFFFF_FFFB, 10, 32'd2, 32'hFFFF_FFFD);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1);

        // MTHI then MFHI
        ex_start = 1'b1;
        ex_op    = OP_MTHI;
        ex_a     = 32'h1234_5678;
        tick();
        clear_inputs();
        ex_op = OP_MFHI;
        #1;
        check_val("mthi_rd", rd_data, 32'h1234_5678);
        check_val("mthi_busy", {31'd0, busy}, 32'd0);
        ex_op = OP_MFLO;
        #1;
        check_val("mflo_rd", rd_data, 32'd1);
        ex_op = 4'd9;
        #1;
        check_val("op9_rd", rd_data, 32'd0);
        clear_inputs();

        // Flushed starts change nothing
        ex_start   = 1'b1;
        ex_flush   = 1'b1;
        ex_op      = OP_MULT;
        ex_a       = 32'd7;
        ex_b       = 32'd9;
        id_mdu_use = 1'b1;
        #1;
        check_val("flush_stall", {31'd0, stall_req}, 32'd0);
        tick();
        check_val("flush_busy", {31'd0, busy}, 32'd0);
        ex_op = OP_MTHI;
        tick();
        clear_inputs();
        tick();
        check_val("flush_hi", hi, 32'h1234_5678);
        check_val("flush_lo", lo, 32'd1);

        // Divide by zero keeps preset HI/LO
        ex_start = 1'b1;
        ex_op    = OP_MTHI;
        ex_a     = 32'hA;
        tick();
        ex_op    = OP_MTLO;
        ex_a     = 32'hB;
        tick();
        clear_inputs();
        run_op("divz", OP_DIV, 32'd100, 32'd0, 10, 32'hA, 32'hB);

        // Start while busy is ignored
        ex_start = 1'b1;
        ex_op    = OP_DIVU;
        ex_a     = 32'd17;
        ex_b     = 32'd5;
        tick();
        clear_inputs();
        tick();
        ex_start = 1'b1;
        ex_op    = OP_MTLO;
        ex_a     = 32'hDEAD;
        tick();
        clear_inputs();
        for (int i = 0; i < 8; i++) tick();
        check_val("ign_busy_last", {31'd0, busy}, 32'd0);
        check_val("ign_hi", hi, 32'd2);
        check_val("ign_lo", lo, 32'd3);

        // Reset mid-DIV aborts the op
        ex_start = 1'b1;
        ex_op    = OP_DIV;
        ex_a     = 32'd50;
        ex_b     = 32'd7;
        tick();
        clear_inputs();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_val("rst_mid_hi", hi, 32'd0);
        check_val("rst_mid_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check_val("rst_abort_hi", hi, 32'd0);
        check_val("rst_abort_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
